control_unit: RTL
=================

Name: control_unit

Overview:
Multicycle MIPS main control FSM. It decodes the instruction-register opcode and sequences the datapath through fetch, decode, execute, memory and write-back. It drives every datapath strobe, including the 2-bit ULAOp consumed by the ALU-control decoder:
- 00 = add
- 01 = sub (beq)
- 10 = R-type, decoded by funct

It also handles a parameterised memory wait.

Parameters:
- MEM_WAIT, default 1: extra wait cycles on every memory read (fetch and lw). Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instruction[31:26] from instruction register
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = regA
- ALUSrcB  out  2  00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ULAOp  out  2  ALU-control operation class
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - reset sampled low at a rising edge forces state RESET (0) and clears the wait counter, from any state, mid-instruction included.
  - In RESET all outputs are 0, including ULAOp = 00 and state_o = 0.
  - The first edge with reset high moves to FETCH.
- Output style: outputs are combinational from state and counter. Any output not listed for a state is 0; ULAOp defaults to 00.
- Wait counter: 4 bits. Cleared on entry to FETCH and MEM_READ; increments each cycle while in those states; saturates at MEM_WAIT.
- State encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, ADDI_EXEC=9, ADDI_WB=10, BRANCH=11, JUMP=12, ILLEGAL=13. Codes 14/15 are unreachable and recover to FETCH.
- FETCH (lasts MEM_WAIT+1 cycles):
  - Every cycle: MemRead=1, IorD=0.
  - Final cycle only (count==MEM_WAIT): IRWrite=1, ALUSrcA=0, ALUSrcB=01, ULAOp=00, PCWrite=1, PCSource=00.
  - PC+4 and IR load occur exactly once per instruction. Then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ULAOp=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 -> ADDI_EXEC
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ULAOp=00. Goes to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: MemRead=1, IorD=1 for MEM_WAIT+1 cycles, then MEM_WB.
- MEM_WB: MemtoReg=1, RegDst=0, RegWrite=1, then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1 for exactly one cycle, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ULAOp=10, then R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ULAOp=00, then ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ULAOp=01, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- ILLEGAL: Illegal=1 for one cycle, no write strobes, then FETCH.
- Latency in cycles, W=MEM_WAIT:
  - R-type, addi, sw: W+4
  - beq, j: W+3
  - lw: 2W+5
- Invariants (bench-checkable every cycle):
  - ULAOp is never 11.
  - MemRead and MemWrite are never both 1.
  - RegWrite is asserted only in MEM_WB, R_WB and ADDI_WB.
  - PCWrite and PCWriteCond are never both 1.
- opcode is sampled only in DECODE; changes in other states are ignored.

Test Plan:
- Reset held low 3 cycles, then released: all outputs 0 and state_o=0 while low; state_o=1 one cycle after release.
- MEM_WAIT=1, opcode=0x00: state sequence 1,1,2,7,8,1. IRWrite and PCWrite only on the 2nd FETCH cycle; ULAOp=10 in state 7; RegDst=RegWrite=1 in state 8.
- MEM_WAIT=2, opcode=0x23: 3 FETCH cycles, then 2, 3, then 3 MEM_READ cycles with IorD=1 and MemRead=1, then MEM_WB with MemtoReg=1. Total 9 cycles.
- opcode=0x2B: MemWrite=1 for exactly one cycle in state 6; RegWrite stays 0 throughout.
- opcode=0x04: ULAOp=01, PCWriteCond=1, PCSource=01 in state 11. opcode=0x02: PCWrite=1, PCSource=10 in state 12.
- opcode=0x3F gives Illegal=1 for one cycle, then FETCH. Reset asserted during MEM_READ: next cycle state 0, MemRead=0, no RegWrite follows.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing
// with a parameterised memory-read wait on instruction fetch and lw.
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ULAOp,
  output logic       Illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [3:0] C_WAIT = 4'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_is_sw;
  logic       w_mem_done;

  assign w_mem_done = (r_cnt == C_WAIT);

  // lw/sw choice is captured in DECODE so later opcode changes cannot redirect MEM_ADDR
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_cnt   <= 4'd0;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_DECODE) begin
        r_is_sw <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RESET:     w_next = S_FETCH;
      S_FETCH:     w_next = w_mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  w_next = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = w_mem_done ? S_MEM_WB : S_MEM_READ;
      S_EXEC_R:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  // Counter restarts on entry to a memory-wait state and saturates at MEM_WAIT
  always_comb begin
    w_cnt_next = r_cnt;
    if ((w_next == S_FETCH || w_next == S_MEM_READ) && (w_next != r_state)) begin
      w_cnt_next = 4'd0;
    end else if ((r_state == S_FETCH || r_state == S_MEM_READ) && (r_cnt < C_WAIT)) begin
      w_cnt_next = r_cnt + 4'd1;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ULAOp       = 2'b00;
    Illegal     = 1'b0;
    state_o     = r_state;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (w_mem_done) begin
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ULAOp   = 2'b10;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ULAOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
